// File: rtl/vga_timing_pkg.sv
// Shared constants, region helpers and fetch FSM encoding for the VGA raster
// timing generator. Defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 11;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 31;
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_FETCH_LEAD = 64;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  function automatic int seg_total(input int vis, input int fr, input int sy, input int bk);
    return vis + fr + sy + bk;
  endfunction

  // True when pos lies in the half-open span [lo, lo+len).
  function automatic logic in_span(input int pos, input int lo, input int len);
    return (pos >= lo) && (pos < lo + len);
  endfunction

endpackage

// File: rtl/vga_pixel_ce.sv
// Pixel-rate divider: a one-clk pixel strobe plus a ~50% duty pixel clock.
// tick is the unregistered strobe the raster counters advance on.
module vga_pixel_ce #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick,
  output logic pix_ce,
  output logic pixel_clock
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] d_q, d_d;
  logic          pix_ce_q, pix_ce_d;
  logic          pixel_clock_q, pixel_clock_d;

  always_comb begin
    tick          = enable && (d_q == D_LAST);
    d_d           = tick ? '0 : d_q + DW'(1);
    pix_ce_d      = tick;
    pixel_clock_d = (d_q >= D_HALF);
    if (!enable) begin
      d_d           = '0;
      pix_ce_d      = 1'b0;
      pixel_clock_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_q           <= '0;
      pix_ce_q      <= 1'b0;
      pixel_clock_q <= 1'b0;
    end else begin
      d_q           <= d_d;
      pix_ce_q      <= pix_ce_d;
      pixel_clock_q <= pixel_clock_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign pixel_clock = pixel_clock_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, sync/active decode and a line
// prefetch handshake toward the framebuffer read path. All outputs registered.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FETCH_LEAD = DEF_FETCH_LEAD,
  localparam int H_TOTAL   = seg_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL   = seg_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int XW        = $clog2(H_TOTAL),
  localparam int YW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_ce,
  output logic          pixel_clock,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic          fetch_req,
  output logic [YW-1:0] fetch_line,
  input  logic          fetch_ack,
  output logic          underrun
);

  logic tick;

  vga_pixel_ce #(.CLK_DIV(CLK_DIV)) u_pixel_ce (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .tick        (tick),
    .pix_ce      (pix_ce),
    .pixel_clock (pixel_clock)
  );

  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  fetch_state_e  state_q, state_d;
  logic [YW-1:0] fetch_line_q, fetch_line_d;
  logic          underrun_q, underrun_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  int            hn, vn, nl;

  always_comb begin
    hn = int'(h_q);
    vn = int'(v_q);
    nl = (vn == V_TOTAL - 1) ? 0 : vn + 1;

    h_d          = h_q;
    v_d          = v_q;
    state_d      = state_q;
    fetch_line_d = fetch_line_q;
    underrun_d   = underrun_q;

    if (tick) begin
      if (hn == H_TOTAL - 1) begin
        h_d = '0;
        v_d = YW'(nl);
      end else begin
        h_d = XW'(hn + 1);
      end
    end

    // A request still pending when pixel 0 of its line is strobed is
    // abandoned: the line is lost and the late fill is latched in underrun.
    case (state_q)
      IDLE: begin
        if (tick && (hn == H_TOTAL - FETCH_LEAD) && (nl < V_VISIBLE)) begin
          state_d      = REQ;
          fetch_line_d = YW'(nl);
        end
      end
      REQ: begin
        if (fetch_ack) begin
          state_d = IDLE;
        end else if (tick && (hn == 0)) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    hsync_d       = in_span(hn, H_VISIBLE + H_FRONT, H_SYNC) ? HS_POL : ~HS_POL;
    vsync_d       = in_span(vn, V_VISIBLE + V_FRONT, V_SYNC) ? VS_POL : ~VS_POL;
    active_d      = in_span(hn, 0, H_VISIBLE) && in_span(vn, 0, V_VISIBLE);
    x_d           = h_q;
    y_d           = v_q;
    line_start_d  = tick && (hn == 0);
    frame_start_d = tick && (hn == 0) && (vn == 0);

    // Disabled: everything but the sticky underrun flag sits at reset values.
    if (!enable) begin
      h_d           = '0;
      v_d           = '0;
      state_d       = IDLE;
      fetch_line_d  = '0;
      underrun_d    = underrun_q;
      hsync_d       = ~HS_POL;
      vsync_d       = ~VS_POL;
      active_d      = 1'b0;
      x_d           = '0;
      y_d           = '0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      h_q           <= '0;
      v_q           <= '0;
      state_q       <= IDLE;
      fetch_line_q  <= '0;
      underrun_q    <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      active_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      state_q       <= state_d;
      fetch_line_q  <= fetch_line_d;
      underrun_q    <= underrun_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign fetch_req   = (state_q == REQ);
  assign fetch_line  = fetch_line_q;
  assign underrun    = underrun_q;

endmodule
